ppm_frame_decoder: RTL

Parametrised PPM receiver that turns a single RC pulse-position stream into a bank of normalised channel values, for the flight-controller input path. It generalises the first-generation decoder with several additions: configurable channel count, pulse limits and clock rate; an on-chip microsecond prescaler; an input synchroniser; an optional 3-tap median filter; frame-complete and channel-count reporting; and a signal-loss failsafe.

---
 rtl/ppm_pkg.sv | 33 +++
 rtl/ppm_frame_decoder_if.sv | 36 +++
 rtl/median3.sv | 23 ++
 rtl/ppm_frame_decoder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// Shared types, widths and the interval-to-sample mapping for the PPM decoder.
// Contents:
//   US_W       width of the microsecond interval counter
//   CNT_W      width of the channel index and ch_count
//   state_e    frame FSM states
//   map_sample clamp a measured interval into the 0..MAX_US-MIN_US-1 channel range
package ppm_pkg;

  localparam int unsigned US_W  = 16;
  localparam int unsigned CNT_W = 5;

  typedef enum logic {
    StHunt,
    StFrame
  } state_e;

  function automatic logic [US_W-1:0] map_sample(input logic [US_W-1:0] dt,
                                                 input int unsigned     min_us,
                                                 input int unsigned     max_us);
    logic [US_W-1:0] min_v;
    logic [US_W-1:0] max_v;
    min_v = US_W'(min_us);
    max_v = US_W'(max_us);
    if (dt < min_v) begin
      return '0;
    end else if (dt >= max_v) begin
      return max_v - min_v - US_W'(1);
    end else begin
      return dt - min_v;
    end
  endfunction

endpackage

// File: rtl/ppm_frame_decoder_if.sv
// Bundle between the PPM decoder and its consumer.
//   ppm          raw asynchronous PPM input
//   ch           per-channel filtered values
//   frame_valid  one-cycle pulse when a frame closes
//   ch_count     channels in the last valid frame
//   failsafe     high while no valid signal is present
// Modports: slave = decoder side, master = consumer/driver side.
interface ppm_frame_decoder_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CH_W   = 12
);
  import ppm_pkg::*;

  logic                         ppm;
  logic [NUM_CH-1:0][CH_W-1:0]  ch;
  logic                         frame_valid;
  logic [CNT_W-1:0]             ch_count;
  logic                         failsafe;

  modport slave (
    input  ppm,
    output ch,
    output frame_valid,
    output ch_count,
    output failsafe
  );

  modport master (
    output ppm,
    input  ch,
    input  frame_valid,
    input  ch_count,
    input  failsafe
  );

endinterface

// File: rtl/median3.sv
// Combinational 3-input median.
//   a, b, c  operands (a = new sample, b/c = history)
//   med      median; on equal operands the earliest (a, then b, then c) is chosen
module median3 #(
  parameter int unsigned CH_W = 12
) (
  input  logic [CH_W-1:0] a,
  input  logic [CH_W-1:0] b,
  input  logic [CH_W-1:0] c,
  output logic [CH_W-1:0] med
);

  always_comb begin
    if ((a >= b && a <= c) || (a <= b && a >= c)) begin
      med = a;
    end else if ((b >= a && b <= c) || (b <= a && b >= c)) begin
      med = b;
    end else begin
      med = c;
    end
  end

endmodule

// File: rtl/ppm_frame_decoder.sv
// PPM receiver: synchronises the input, measures rising-edge intervals in microseconds,
// maps each interval to a channel value, optionally median-filters it and tracks frames.
//   clk   clock
//   rst   synchronous active-low reset
//   bus   slave side of ppm_frame_decoder_if (ppm in; ch, frame_valid, ch_count,
//         failsafe out)
module ppm_frame_decoder
  import ppm_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned CH_W       = 12,
  parameter int unsigned MIN_US     = 1000,
  parameter int unsigned MAX_US     = 2000,
  parameter int unsigned SYNC_US    = 5000,
  parameter int unsigned TIMEOUT_US = 25000,
  parameter int unsigned MEDIAN     = 1
) (
  input logic                clk,
  input logic                rst,
  ppm_frame_decoder_if.slave bus
);

  localparam int unsigned       PRESC_W     = $clog2(CLK_PER_US);
  localparam int unsigned       IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_US - 1);
  localparam logic [US_W-1:0]   SYNC_LIM    = US_W'(SYNC_US);
  localparam logic [US_W-1:0]   TIMEOUT_LIM = US_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0]  CH_LIM      = CNT_W'(NUM_CH);

  logic sync1_q, sync2_q, hist_q;
  logic rise, us_tick, is_sync, timeout;

  logic [PRESC_W-1:0] presc_q;
  logic [US_W-1:0]    dt_q;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            idx_q, idx_d;
  logic [NUM_CH-1:0][CH_W-1:0] ch_q, ch_d;
  logic [NUM_CH-1:0][CH_W-1:0] h1_q, h1_d;
  logic [NUM_CH-1:0][CH_W-1:0] h2_q, h2_d;
  logic                        fv_q, fv_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        fs_q, fs_d;

  logic [IDX_W-1:0] sel;
  logic [CH_W-1:0]  samp;
  logic [CH_W-1:0]  med;

  // Synchroniser, edge history, prescaler and interval counter. Reset high so that a
  // line idling high out of reset is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      presc_q <= '0;
      dt_q    <= '0;
    end else begin
      sync1_q <= bus.ppm;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (rise) begin
        // The tick coinciding with an edge is dropped on purpose.
        presc_q <= '0;
        dt_q    <= '0;
      end else begin
        presc_q <= us_tick ? '0 : presc_q + PRESC_W'(1);
        if (us_tick && dt_q != '1) begin
          dt_q <= dt_q + US_W'(1);
        end
      end
    end
  end

  assign rise    = sync2_q & ~hist_q;
  assign us_tick = (presc_q == PRESC_LAST);
  assign is_sync = (dt_q > SYNC_LIM);
  assign timeout = (dt_q >= TIMEOUT_LIM);
  assign sel     = idx_q[IDX_W-1:0];
  assign samp    = CH_W'(map_sample(dt_q, MIN_US, MAX_US));

  // Single median instance shared by all channels, steered by the current index.
  median3 #(
    .CH_W(CH_W)
  ) u_median3 (
    .a  (samp),
    .b  (h1_q[sel]),
    .c  (h2_q[sel]),
    .med(med)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    fv_d    = 1'b0;
    cnt_d   = cnt_q;
    fs_d    = fs_q;
    if (rise) begin
      case (state_q)
        StHunt: begin
          if (is_sync) begin
            state_d = StFrame;
            idx_d   = '0;
          end
        end
        StFrame: begin
          if (is_sync) begin
            if (idx_q != '0) begin
              fv_d  = 1'b1;
              cnt_d = idx_q;
              fs_d  = 1'b0;
            end
            idx_d = '0;
          end else if (idx_q < CH_LIM) begin
            ch_d[sel] = (MEDIAN != 0) ? med : samp;
            h1_d[sel] = samp;
            h2_d[sel] = h1_q[sel];
            idx_d     = idx_q + CNT_W'(1);
          end else begin
            // Overrun: drop the frame, keep what was already written.
            state_d = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end else if (timeout) begin
      fs_d    = 1'b1;
      state_d = StHunt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StHunt;
      idx_q   <= '0;
      ch_q    <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      fv_q    <= 1'b0;
      cnt_q   <= '0;
      fs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      fv_q    <= fv_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.ch          = ch_q;
  assign bus.frame_valid = fv_q;
  assign bus.ch_count    = cnt_q;
  assign bus.failsafe    = fs_q;

endmodule
